// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the EXE-stage multiplier/divider and owns HI/LO.
// Multiplies and mthi/mtlo complete in one cycle from IDLE; divides issue a
// single valid pulse to an external pipelined divider and wait for its result,
// with a watchdog and a drain state that swallows results of cancelled divides.
module muldiv_sequencer #(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        cancel,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        req_ready,
    output logic        busy,
    output logic        done,
    output logic        mult_signed,
    input  logic [63:0] mult_p,
    output logic        div_s_tvalid,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_dout_tvalid,
    input  logic [63:0] div_dout,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       hi_nxt, lo_nxt, dividend_nxt, divisor_nxt;
    logic              signed_nxt, done_nxt, terr_nxt;
    logic              issue_q, issue_nxt;

    // Status decodes and combinational selects
    assign busy         = (state != IDLE);
    assign req_ready    = (state == IDLE);
    assign mult_signed  = ~req_op[0];
    // A flush during the issue cycle must never reach the divider
    assign div_s_tvalid = issue_q & ~cancel;

    // Next-state and register-update decisions
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        hi_nxt       = hi;
        lo_nxt       = lo;
        dividend_nxt = div_dividend;
        divisor_nxt  = div_divisor;
        signed_nxt   = div_signed;
        terr_nxt     = timeout_err;
        done_nxt     = 1'b0;
        issue_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && !cancel) begin
                    case (req_op)
                        3'b000, 3'b001: begin
                            {hi_nxt, lo_nxt} = mult_p;
                            done_nxt         = 1'b1;
                        end
                        3'b100: begin
                            hi_nxt   = src_a;
                            done_nxt = 1'b1;
                        end
                        3'b101: begin
                            lo_nxt   = src_a;
                            done_nxt = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            // Divide by zero completes at once with HI/LO untouched
                            if (src_b == 32'd0) begin
                                done_nxt = 1'b1;
                            end else begin
                                dividend_nxt = src_a;
                                divisor_nxt  = src_b;
                                signed_nxt   = ~req_op[0];
                                issue_nxt    = 1'b1;
                                state_nxt    = ISSUE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = cancel ? IDLE : WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt + 1'b1;
                if (div_dout_tvalid) begin
                    if (!cancel) begin
                        {hi_nxt, lo_nxt} = div_dout;
                        done_nxt         = 1'b1;
                    end
                    state_nxt = IDLE;
                end else if (cancel) begin
                    state_nxt = DRAIN;
                end else if (cnt == CNT_LAST) begin
                    terr_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                cnt_nxt = cnt + 1'b1;
                if (div_dout_tvalid) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    terr_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, architectural HI/LO and divider operand registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            cnt          <= '0;
            hi           <= '0;
            lo           <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_signed   <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            issue_q      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            hi           <= hi_nxt;
            lo           <= lo_nxt;
            div_dividend <= dividend_nxt;
            div_divisor  <= divisor_nxt;
            div_signed   <= signed_nxt;
            done         <= done_nxt;
            timeout_err  <= terr_nxt;
            issue_q      <= issue_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed requests, a behavioural divider
// with programmable latency, and a scoreboard checking HI/LO on every done.
module tb_muldiv_sequencer;

    logic        clk;
    logic        aresetn;
    logic        cancel;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        req_ready;
    logic        busy;
    logic        done;
    logic        mult_signed;
    logic [63:0] mult_p;
    logic        div_s_tvalid;
    logic        div_signed;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_dout_tvalid;
    logic [63:0] div_dout;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    // Divider model controls (written by stimulus) and observations (written by model)
    int          div_lat  = -1;
    logic [63:0] div_resp = '0;
    int          pulse_cnt = 0;
    logic        iss_signed;
    logic [31:0] iss_dividend;
    logic [31:0] iss_divisor;

    muldiv_sequencer #(.DIV_TIMEOUT(64), .CNT_W(7)) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .cancel          (cancel),
        .req_valid       (req_valid),
        .req_op          (req_op),
        .src_a           (src_a),
        .src_b           (src_b),
        .req_ready       (req_ready),
        .busy            (busy),
        .done            (done),
        .mult_signed     (mult_signed),
        .mult_p          (mult_p),
        .div_s_tvalid    (div_s_tvalid),
        .div_signed      (div_signed),
        .div_dividend    (div_dividend),
        .div_divisor     (div_divisor),
        .div_dout_tvalid (div_dout_tvalid),
        .div_dout        (div_dout),
        .hi              (hi),
        .lo              (lo),
        .timeout_err     (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural divider: returns div_resp div_lat cycles after the issue edge
    initial begin
        int  cd;
        logic seen, sig;
        logic [31:0] dvd, dvs;
        cd = -1;
        div_dout_tvalid = 1'b0;
        div_dout = '0;
        forever begin
            @(negedge clk);
            seen = div_s_tvalid;
            sig  = div_signed;
            dvd  = div_dividend;
            dvs  = div_divisor;
            @(posedge clk);
            #1;
            div_dout_tvalid = 1'b0;
            if (seen === 1'b1) begin
                pulse_cnt++;
                iss_signed   = sig;
                iss_dividend = dvd;
                iss_divisor  = dvs;
                cd = div_lat;
            end else if (cd > 0) begin
                cd--;
            end
            if (cd == 0) begin
                div_dout_tvalid = 1'b1;
                div_dout = div_resp;
                cd = -1;
            end
        end
    end

    // Scoreboard monitor: every done must match the oldest expected {hi,lo}
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    check("done_hilo", {hi, lo}, e);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request for one cycle; returns mult_signed seen during it
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] p, output logic ms);
        req_valid = 1'b1;
        req_op    = op;
        src_a     = a;
        src_b     = b;
        mult_p    = p;
        #1;
        ms = mult_signed;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'b111;
    endtask

    // Count busy cycles until the sequencer is idle again
    task automatic wait_idle(input string name, output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) return;
            n++;
        end
        checks++;
        failures++;
        $display("FAIL %s_wait_idle: got busy after 300 cycles expected idle", name);
    endtask

    initial begin
        logic ms;
        int   n;
        int   pc;
        aresetn   = 1'b0;
        cancel    = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'b111;
        src_a     = '0;
        src_b     = '0;
        mult_p    = '0;
        tick(3);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        check("rst_done", done, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_s_tvalid", div_s_tvalid, 0);
        aresetn = 1'b1;
        tick(2);

        // mult -3 * 5
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
        send(3'b000, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, ms);
        check("mult_signed_mult", ms, 1);
        @(negedge clk);
        check("mult_busy", busy, 0);
        tick(2);

        // multu 0xFFFFFFFF * 2
        exp_q.push_back({32'h00000001, 32'hFFFFFFFE});
        send(3'b001, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, ms);
        check("mult_signed_multu", ms, 0);
        tick(2);

        // mthi then mtlo back-to-back
        exp_q.push_back({32'h12345678, 32'hFFFFFFFE});
        exp_q.push_back({32'h12345678, 32'hCAFEBABE});
        send(3'b100, 32'h12345678, 32'd0, 64'd0, ms);
        send(3'b101, 32'hCAFEBABE, 32'd0, 64'd0, ms);
        tick(2);

        // reserved op: no effect, no done
        send(3'b110, 32'hDEADBEEF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, ms);
        tick(2);
        check("reserved_hilo", {hi, lo}, {32'h12345678, 32'hCAFEBABE});

        // divu 100/7 with divider latency 20
        pc = pulse_cnt;
        div_lat  = 20;
        div_resp = {32'd2, 32'd14};
        exp_q.push_back({32'd2, 32'd14});
        send(3'b011, 32'd100, 32'd7, 64'd0, ms);
        wait_idle("divu", n);
        check("divu_busy_cycles", n, 22);
        check("divu_pulses", pulse_cnt - pc, 1);
        check("divu_signed", iss_signed, 0);
        check("divu_dividend", iss_dividend, 100);
        check("divu_divisor", iss_divisor, 7);
        tick(2);

        // div -7/2: quotient -3, remainder -1
        div_resp = {32'hFFFFFFFF, 32'hFFFFFFFD};
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        send(3'b010, 32'hFFFFFFF9, 32'd2, 64'd0, ms);
        wait_idle("div", n);
        check("div_signed", iss_signed, 1);
        tick(2);

        // divide by zero: immediate done, no issue, HI/LO kept
        pc = pulse_cnt;
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        send(3'b011, 32'd5, 32'd0, 64'd0, ms);
        @(negedge clk);
        check("div0_busy", busy, 0);
        tick(3);
        check("div0_pulses", pulse_cnt - pc, 0);

        // cancel in WAIT cycle 5; result at 20 is drained
        div_resp = {32'h0BADF00D, 32'h0BADF00D};
        send(3'b011, 32'd100, 32'd7, 64'd0, ms);
        tick(5);
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
        @(negedge clk);
        check("drain_busy", busy, 1);
        check("drain_ready", req_ready, 0);
        n = 0;
        while (div_dout_tvalid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_tvalid_seen", div_dout_tvalid, 1);
        check("drain_ready_at_tvalid", req_ready, 0);
        @(negedge clk);
        check("drain_ready_after", req_ready, 1);
        check("drain_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        tick(2);

        // watchdog: divider never answers
        div_lat = -1;
        send(3'b011, 32'd9, 32'd3, 64'd0, ms);
        check("timeout_pre", timeout_err, 0);
        wait_idle("timeout", n);
        check("timeout_busy_cycles", n, 65);
        check("timeout_flag", timeout_err, 1);
        check("timeout_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        tick(3);
        check("timeout_sticky", timeout_err, 1);

        // reset mid-WAIT, then a stray late result
        div_lat  = 20;
        div_resp = {32'h11111111, 32'h22222222};
        send(3'b011, 32'd100, 32'd7, 64'd0, ms);
        tick(5);
        aresetn = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_timeout", timeout_err, 0);
        tick(2);
        aresetn = 1'b1;
        tick(25);
        check("stray_hilo", {hi, lo}, 64'd0);
        check("stray_busy", busy, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the EXE-stage multiply/divide resources and owns the HI/LO architectural registers.
- Accepts one mult/multu/div/divu/mthi/mtlo request from EXE.
- Issues the single-cycle valid pulse to the pipelined AXI-stream divider and waits for its result, or captures the combinational multiplier product directly.
- Discards in-flight divider results on pipeline cancel, and raises busy/done so EXE can stall and release.

Parameters:
- DIV_TIMEOUT, default 64: watchdog limit, in cycles, on the divider's dout_tvalid after issue.
- CNT_W, default 7: counter width; must satisfy 2^CNT_W > DIV_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- aresetn  in  1  asynchronous active-low reset
- cancel  in  1  pipeline flush (exception/eret); synchronous
- req_valid  in  1  EXE presents a request
- req_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved
- src_a  in  32  forwarded RS value
- src_b  in  32  forwarded RT value
- req_ready  out  1  sequencer accepts req_valid this cycle
- busy  out  1  operation or drain in progress
- done  out  1  one-cycle pulse: HI/LO updated for the accepted request
- mult_signed  out  1  selects signed product; combinational from req_op[0]==0
- mult_p  in  64  combinational product of src_a*src_b
- div_s_tvalid  out  1  dividend/divisor valid pulse to divider
- div_signed  out  1  1 selects signed divider, 0 unsigned
- div_dividend  out  32  latched src_a
- div_divisor  out  32  latched src_b
- div_dout_tvalid  in  1  divider result valid (either divider)
- div_dout  in  64  [63:32] remainder, [31:0] quotient
- hi  out  32  HI register
- lo  out  32  LO register
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (aresetn=0, asynchronous): state=IDLE; hi, lo, counter, div_dividend, div_divisor = 0; div_signed, div_s_tvalid, done, timeout_err = 0.
- States: IDLE, ISSUE, WAIT, DRAIN.
- busy = (state != IDLE). req_ready = (state == IDLE).
- All outputs other than mult_signed and the two decodes below are registered.

IDLE:
- A request is accepted when req_valid & ~cancel.
- req_valid & cancel in the same cycle: request dropped, no state change, no done.
- mult/multu: {hi,lo} <= mult_p at the edge; done pulses the next cycle; stay IDLE. Latency is 1.
- mthi: hi <= src_a, done next cycle. mtlo: lo <= src_a, done next cycle.
- div/divu with src_b==0: hi/lo unchanged, done next cycle, stay IDLE, no divider issue.
- div/divu with src_b!=0: latch the operands and div_signed = ~req_op[0]; go to ISSUE.
- Reserved op: ignored; no done.

ISSUE:
- div_s_tvalid = 1 for exactly this cycle; counter cleared; go to WAIT.
- cancel in ISSUE: div_s_tvalid is forced 0 (gated combinationally); go to IDLE.

WAIT:
- counter increments each cycle.
- div_dout_tvalid & ~cancel: lo <= div_dout[31:0], hi <= div_dout[63:32]; done next cycle; go to IDLE.
- cancel & ~div_dout_tvalid: go to DRAIN; the result is discarded.
- cancel & div_dout_tvalid together: result discarded; go directly to IDLE; no done.
- counter == DIV_TIMEOUT-1 without tvalid: timeout_err <= 1; go to IDLE; no done; HI/LO unchanged.

DRAIN:
- req_ready=0. The first div_dout_tvalid is consumed without writing; go to IDLE.
- The watchdog also applies here, with the same timeout action.
- cancel in DRAIN has no further effect.

Other rules:
- timeout_err clears only on reset.
- done never asserts in the same cycle as a reset.
- A division result always updates HI and LO together, in the same cycle; partial updates are not allowed.
- Back-to-back requests: a new request may be accepted in the cycle done is high, since state is already IDLE.
- Reset mid-WAIT: the block returns to IDLE immediately. A late div_dout_tvalid arriving in IDLE is ignored.

Test Plan:
- mult: src_a=0xFFFFFFFD (-3), src_b=5, mult_p=0xFFFFFFFF_FFFFFFF1 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFF1, done=1 for one cycle, busy never set.
- divu 100/7, divider model latency 20 -> div_s_tvalid exactly one pulse with div_signed=0; busy for 22 cycles; then lo=14, hi=2, done pulse.
- div 0xFFFFFFF9 (-7) / 2 -> div_signed=1; lo=0xFFFFFFFD, hi=0xFFFFFFFF after the result.
- cancel in WAIT at cycle 5, result returns at cycle 20 -> state goes to DRAIN, hi/lo unchanged, no done, req_ready returns 1 the cycle after tvalid.
- div by zero, src_b=0 -> no div_s_tvalid, hi/lo unchanged, done next cycle. Separately, no tvalid for 64 cycles -> timeout_err=1, IDLE, no done.
- aresetn pulsed low mid-WAIT -> hi=lo=0, busy=0 immediately; a later stray tvalid changes nothing.
